// File: rtl/scalar_wb_arbiter.sv
// scalar_wb_arbiter: round-robin arbiter sharing the single scalar
// register-file write port among numReq write-back requesters.
// The grant is combinational; the chosen write is registered, so it
// appears on regWrEn/regToWrite/dataIn one cycle after the ack.
// Optional feature: define SCALAR_WB_FWD_EN to enable the read-port
// forwarding compare on rSel1/rSel2; otherwise fwd* outputs are tied to 0.
module scalar_wb_arbiter #(
    parameter int regSize     = 8,
    parameter int regQuantity = 4,
    parameter int selBits     = 2,
    parameter int numReq      = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        hold,
    input  logic [numReq-1:0]           wbReq,
    input  logic [numReq*selBits-1:0]   wbReg,
    input  logic [numReq*regSize-1:0]   wbData,
    output logic [numReq-1:0]           wbAck,
    output logic                        regWrEn,
    output logic [selBits-1:0]          regToWrite,
    output logic [regSize-1:0]          dataIn,
    input  logic [selBits-1:0]          rSel1,
    input  logic [selBits-1:0]          rSel2,
    output logic                        fwd1Valid,
    output logic                        fwd2Valid,
    output logic [regSize-1:0]          fwd1Data,
    output logic [regSize-1:0]          fwd2Data,
    output logic [15:0]                 collisionCnt
);

    localparam int unsigned NREQ  = numReq;
    localparam int          PTR_W = (numReq > 1) ? $clog2(numReq) : 1;

    logic [PTR_W-1:0]   r_rrPtr;
    logic               r_regWrEn;
    logic [selBits-1:0] r_regToWrite;
    logic [regSize-1:0] r_dataIn;
    logic [15:0]        r_collisionCnt;

    logic               w_grantValid;
    logic [PTR_W-1:0]   w_grantIdx;
    logic [PTR_W-1:0]   w_candIdx;
    int unsigned        w_cand;
    logic [numReq-1:0]  w_ack;
    logic               w_multiReq;
    logic [selBits-1:0] w_regArr  [numReq];
    logic [regSize-1:0] w_dataArr [numReq];

    // The register count is not needed by the datapath; it is kept for
    // interface compatibility only.
    logic [31:0] w_unused_cfg;
    assign w_unused_cfg = 32'(regQuantity);

    // Unpack the flat requester buses into per-requester slices.
    for (genvar gi = 0; gi < numReq; gi++) begin : g_unpack
        assign w_regArr[gi]  = wbReg[gi*selBits +: selBits];
        assign w_dataArr[gi] = wbData[gi*regSize +: regSize];
    end

    // Round-robin search from r_rrPtr upward with wrap; first set request wins.
    always_comb begin
        w_grantValid = 1'b0;
        w_grantIdx   = '0;
        w_candIdx    = '0;
        w_cand       = 0;
        w_ack        = '0;
        if (reset && !hold) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                w_cand    = (32'(r_rrPtr) + k) % NREQ;
                w_candIdx = PTR_W'(w_cand);
                if (!w_grantValid && wbReq[w_candIdx]) begin
                    w_grantValid = 1'b1;
                    w_grantIdx   = w_candIdx;
                end
            end
            if (w_grantValid) begin
                w_ack[w_grantIdx] = 1'b1;
            end
        end
    end

    assign wbAck = w_ack;

    // Clearing the lowest set bit leaves something only if two or more are set.
    assign w_multiReq = |(wbReq & (wbReq - 1'b1));

    // Round-robin pointer: advance past the winner, hold otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rrPtr <= '0;
        end else if (w_grantValid) begin
            r_rrPtr <= (w_grantIdx == PTR_W'(numReq - 1)) ? '0 : w_grantIdx + 1'b1;
        end
    end

    // Register the granted write toward the register file.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_regWrEn    <= 1'b0;
            r_regToWrite <= '0;
            r_dataIn     <= '0;
        end else if (w_grantValid) begin
            r_regWrEn    <= 1'b1;
            r_regToWrite <= w_regArr[w_grantIdx];
            r_dataIn     <= w_dataArr[w_grantIdx];
        end else begin
            r_regWrEn    <= 1'b0;
        end
    end

    // Saturating count of unstalled cycles with contending requesters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_collisionCnt <= '0;
        end else if (!hold && w_multiReq && (r_collisionCnt != '1)) begin
            r_collisionCnt <= r_collisionCnt + 16'd1;
        end
    end

    assign regWrEn      = r_regWrEn;
    assign regToWrite   = r_regToWrite;
    assign dataIn       = r_dataIn;
    assign collisionCnt = r_collisionCnt;

`ifdef SCALAR_WB_FWD_EN
    assign fwd1Valid = r_regWrEn && (r_regToWrite == rSel1);
    assign fwd2Valid = r_regWrEn && (r_regToWrite == rSel2);
    assign fwd1Data  = fwd1Valid ? r_dataIn : '0;
    assign fwd2Data  = fwd2Valid ? r_dataIn : '0;
`else
    logic w_unused_rsel;
    assign w_unused_rsel = ^{rSel1, rSel2};
    assign fwd1Valid = 1'b0;
    assign fwd2Valid = 1'b0;
    assign fwd1Data  = '0;
    assign fwd2Data  = '0;
`endif

endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// Testbench for scalar_wb_arbiter: a scoreboard queue holds the writes the
// bench expects from each grant; they are popped when regWrEn appears.
module tb_scalar_wb_arbiter;

    typedef struct packed {
        logic [1:0] r;
        logic [7:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        hold;
    logic [2:0]  wbReq;
    logic [5:0]  wbReg;
    logic [23:0] wbData;
    logic [2:0]  wbAck;
    logic        regWrEn;
    logic [1:0]  regToWrite;
    logic [7:0]  dataIn;
    logic [1:0]  rSel1, rSel2;
    logic        fwd1Valid, fwd2Valid;
    logic [7:0]  fwd1Data, fwd2Data;
    logic [15:0] collisionCnt;

    int total = 0;
    int bad   = 0;

    // reference model state
    int         m_ptr  = 0;
    int         m_coll = 0;
    logic       m_we   = 1'b0;
    logic [1:0] m_reg  = '0;
    logic [7:0] m_data = '0;
    wr_t        q[$];

    always #5 clk = ~clk;

    scalar_wb_arbiter #(
        .regSize(8), .regQuantity(4), .selBits(2), .numReq(3)
    ) dut (
        .clk(clk), .reset(reset), .hold(hold),
        .wbReq(wbReq), .wbReg(wbReg), .wbData(wbData), .wbAck(wbAck),
        .regWrEn(regWrEn), .regToWrite(regToWrite), .dataIn(dataIn),
        .rSel1(rSel1), .rSel2(rSel2),
        .fwd1Valid(fwd1Valid), .fwd2Valid(fwd2Valid),
        .fwd1Data(fwd1Data), .fwd2Data(fwd2Data),
        .collisionCnt(collisionCnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [2:0] req, input int ptr);
        for (int k = 0; k < 3; k++) begin
            int i;
            i = (ptr + k) % 3;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    task automatic check_fwd();
        logic       v1, v2;
        logic [7:0] d1, d2;
`ifdef SCALAR_WB_FWD_EN
        v1 = m_we && (m_reg == rSel1);
        v2 = m_we && (m_reg == rSel2);
`else
        v1 = 1'b0;
        v2 = 1'b0;
`endif
        d1 = v1 ? m_data : 8'h00;
        d2 = v2 ? m_data : 8'h00;
        check("fwd1Valid", 32'(fwd1Valid), 32'(v1));
        check("fwd2Valid", 32'(fwd2Valid), 32'(v2));
        check("fwd1Data", 32'(fwd1Data), 32'(d1));
        check("fwd2Data", 32'(fwd2Data), 32'(d2));
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle(input logic [2:0] req, input logic h, input logic [5:0] regs,
                         input logic [23:0] data, input logic [1:0] s1, input logic [1:0] s2,
                         output int g);
        logic [2:0] exp_ack;
        wr_t        e;
        wbReq = req; hold = h; wbReg = regs; wbData = data; rSel1 = s1; rSel2 = s2;
        #1;
        g       = h ? -1 : rr_pick(req, m_ptr);
        exp_ack = (g >= 0) ? 3'(1 << g) : 3'b000;
        check("wbAck", 32'(wbAck), 32'(exp_ack));
        check_fwd();
        if (!h && $countones(req) >= 2 && m_coll < 65535) m_coll++;
        if (g >= 0) begin
            e.r = regs[g*2 +: 2];
            e.d = data[g*8 +: 8];
            q.push_back(e);
            m_ptr  = (g + 1) % 3;
            m_reg  = e.r;
            m_data = e.d;
        end
        m_we = (g >= 0);
        @(posedge clk);
        #1;
        check("regWrEn", 32'(regWrEn), 32'(m_we));
        if (regWrEn) begin
            if (q.size() == 0) begin
                check("sb_underflow", 32'(q.size()), 32'd1);
            end else begin
                e = q.pop_front();
                check("regToWrite", 32'(regToWrite), 32'(e.r));
                check("dataIn", 32'(dataIn), 32'(e.d));
            end
        end
        check("collisionCnt", 32'(collisionCnt), 32'(m_coll));
        @(negedge clk);
    endtask

    logic       pend [3];
    logic [1:0] preg [3];
    logic [7:0] pdat [3];

    initial begin
        int g;
        logic [2:0]  rq;
        logic [5:0]  rg;
        logic [23:0] dt;

        reset = 1'b0; hold = 1'b0; wbReq = '0; wbReg = '0; wbData = '0;
        rSel1 = '0; rSel2 = '0;
        @(negedge clk); @(negedge clk);
        check("rst_regWrEn", 32'(regWrEn), 0);
        check("rst_regToWrite", 32'(regToWrite), 0);
        check("rst_dataIn", 32'(dataIn), 0);
        check("rst_collisionCnt", 32'(collisionCnt), 0);
        check("rst_wbAck", 32'(wbAck), 0);
        check_fwd();
        reset = 1'b1;

        // full contention, acked requesters drop out: grants 0,1,2
        cycle(3'b111, 1'b0, {2'd2, 2'd1, 2'd0}, {8'hA2, 8'hA1, 8'hA0}, 2'd0, 2'd1, g);
        check("cont_g0", 32'(g), 0);
        cycle(3'b110, 1'b0, {2'd2, 2'd1, 2'd0}, {8'hA2, 8'hA1, 8'hA0}, 2'd1, 2'd2, g);
        check("cont_g1", 32'(g), 1);
        cycle(3'b100, 1'b0, {2'd2, 2'd1, 2'd0}, {8'hA2, 8'hA1, 8'hA0}, 2'd2, 2'd2, g);
        check("cont_g2", 32'(g), 2);
        check("cont_coll", 32'(collisionCnt), 2);

        // single requester 1 writing FE to register 1
        cycle(3'b010, 1'b0, {2'd0, 2'd1, 2'd0}, {8'h00, 8'hFE, 8'h00}, 2'd1, 2'd0, g);
        cycle(3'b000, 1'b0, '0, '0, 2'd1, 2'd0, g);

        // wrap-around: pointer now 2, requests 0 and 1 -> 0 then 1
        cycle(3'b011, 1'b0, {2'd0, 2'd3, 2'd2}, {8'h00, 8'h31, 8'h30}, 2'd2, 2'd3, g);
        check("wrap_g0", 32'(g), 0);
        cycle(3'b010, 1'b0, {2'd0, 2'd3, 2'd2}, {8'h00, 8'h31, 8'h30}, 2'd2, 2'd3, g);
        check("wrap_g1", 32'(g), 1);

        // hold for three cycles, then grant
        for (int i = 0; i < 3; i++)
            cycle(3'b001, 1'b1, {2'd0, 2'd0, 2'd3}, {8'h00, 8'h00, 8'h77}, 2'd3, 2'd0, g);
        cycle(3'b001, 1'b0, {2'd0, 2'd0, 2'd3}, {8'h00, 8'h00, 8'h77}, 2'd3, 2'd0, g);
        check("hold_release_g", 32'(g), 0);

        // back-to-back writes to the same register keep grant order
        rq = 3'b111;
        for (int i = 0; i < 3; i++) begin
            cycle(rq, 1'b0, {2'd2, 2'd2, 2'd2}, {8'h33, 8'h22, 8'h11}, 2'd2, 2'd2, g);
            if (g >= 0) rq[g] = 1'b0;
        end

        // forwarding: write FA to register 3, then read selects 3 and 1
        cycle(3'b100, 1'b0, {2'd3, 2'd0, 2'd0}, {8'hFA, 8'h00, 8'h00}, 2'd0, 2'd0, g);
        cycle(3'b000, 1'b0, '0, '0, 2'd3, 2'd1, g);

        // reset between edges while a write is pending on the output
        cycle(3'b001, 1'b0, {2'd0, 2'd0, 2'd1}, {8'h00, 8'h00, 8'h5A}, 2'd0, 2'd0, g);
        #2;
        wbReq = 3'b111; rSel1 = 2'd1; rSel2 = 2'd1;
        reset = 1'b0;
        #1;
        q.delete();
        m_ptr = 0; m_coll = 0; m_we = 1'b0; m_reg = '0; m_data = '0;
        check("mid_regWrEn", 32'(regWrEn), 0);
        check("mid_regToWrite", 32'(regToWrite), 0);
        check("mid_dataIn", 32'(dataIn), 0);
        check("mid_wbAck", 32'(wbAck), 0);
        check("mid_collisionCnt", 32'(collisionCnt), 0);
        check_fwd();
        @(posedge clk);
        #1;
        check("mid_edge_regWrEn", 32'(regWrEn), 0);
        check("mid_edge_coll", 32'(collisionCnt), 0);
        @(negedge clk);
        reset = 1'b1;
        cycle(3'b111, 1'b0, {2'd2, 2'd1, 2'd0}, {8'hC2, 8'hC1, 8'hC0}, 2'd0, 2'd1, g);
        check("post_rst_g", 32'(g), 0);

        // random traffic with requesters holding until acked
        for (int i = 0; i < 3; i++) pend[i] = 1'b0;
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && ($urandom_range(0, 2) != 0)) begin
                    pend[i] = 1'b1;
                    preg[i] = 2'($urandom_range(0, 3));
                    pdat[i] = 8'($urandom_range(0, 255));
                end
                rq[i]        = pend[i];
                rg[i*2 +: 2] = preg[i];
                dt[i*8 +: 8] = pdat[i];
            end
            cycle(rq, ($urandom_range(0, 7) == 0), rg, dt,
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), g);
            if (g >= 0) pend[g] = 1'b0;
        end
        cycle(3'b000, 1'b0, '0, '0, 2'd0, 2'd0, g);

        check("sb_drained", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scalar_wb_arbiter.md
SCALAR_WB_ARBITER -- requirements
Module: scalar_wb_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- regSize, 8, data width
- regQuantity, 4, number of scalar registers
- selBits, 2, register-select width
- numReq, 3, number of write-back requesters
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock, rising-edge
- reset  in  1  asynchronous, active-low reset
- hold  in  1  pipeline stall; blocks all grants
- wbReq  in  numReq  per-requester write request
- wbReg  in  numReq*selBits  target register, requester i at [i*selBits +: selBits]
- wbData  in  numReq*regSize  write data, requester i at [i*regSize +: regSize]
- wbAck  out  numReq  one-hot grant/acknowledge
- regWrEn  out  1  register-file write enable
- regToWrite  out  selBits  register-file write select
- dataIn  out  regSize  register-file write data
- rSel1, rSel2  in  selBits each  register-file read selects (forwarding compare)
- fwd1Valid, fwd2Valid  out  1 each  forwarding hit, ports 1/2
- fwd1Data, fwd2Data  out  regSize each  forwarded data, ports 1/2
- collisionCnt  out  16  saturating count of contention cycles

Function
REQ-003 Block SHALL share the single scalar register-file write port among numReq requesters.
REQ-004 Requester i SHALL hold wbReq[i], its wbReg slice and its wbData slice stable from assertion until the cycle wbAck[i]=1; it SHALL deassert or present a new request after that cycle.
REQ-005 wbAck SHALL be combinational, at most one bit set, and all-zero when hold=1, when no wbReq bit is set, or while reset=0.
REQ-006 Arbitration SHALL be round-robin: the search starts at rrPtr and proceeds upward, wrapping from numReq-1 to 0; the first set wbReq bit wins.
REQ-007 After a grant to index g, rrPtr SHALL become (g+1) mod numReq at the next edge; without a grant rrPtr SHALL hold.
REQ-008 Output registers SHALL load at the clock edge ending the ack cycle N: regWrEn<=1, regToWrite<=wbReg[g], dataIn<=wbData[g]; with no grant regWrEn<=0 and regToWrite/dataIn hold.
REQ-009 Latency: regWrEn SHALL be high during cycle N+1, and the register file SHALL commit the write at the end of N+1.
REQ-010 Back-to-back grants SHALL be allowed every cycle; sustained throughput SHALL be one write per cycle.
REQ-011 Consecutive writes to the same register SHALL be issued in grant order with no merging.
REQ-012 collisionCnt SHALL increment by 1 each cycle with two or more wbReq bits set and hold=0; it SHALL saturate at 16'hFFFF.
REQ-013 hold=1 SHALL freeze rrPtr and collisionCnt and force regWrEn<=0 at the next edge.

Reset
REQ-014 Reset SHALL take effect immediately when reset=0, independent of clk.
REQ-015 During reset: rrPtr=0, regWrEn=0, regToWrite=0, dataIn=0, collisionCnt=0, wbAck=0, fwd1Valid=fwd2Valid=0, fwd1Data=fwd2Data=0.
REQ-016 A write registered but not yet committed when reset asserts SHALL be dropped; requesters SHALL re-request after reset deasserts.

Configuration
REQ-017 Macro SCALAR_WB_FWD_EN SHALL control forwarding.
REQ-018 With SCALAR_WB_FWD_EN defined: fwdkValid SHALL equal regWrEn && (regToWrite==rSelk), and fwdkData SHALL equal dataIn when fwdkValid=1, else 0 (k=1,2); both paths are combinational.
REQ-019 Without SCALAR_WB_FWD_EN: fwd1Valid, fwd2Valid, fwd1Data and fwd2Data SHALL be constant 0 and no comparators SHALL be synthesized.

Verification
REQ-020 Single requester: wbReq=3'b010, wbReg[1]=1, wbData[1]=8'hFE -> wbAck=3'b010 that cycle; next cycle regWrEn=1, regToWrite=1, dataIn=8'hFE; register 1 reads 8'hFE afterwards.
REQ-021 Full contention: wbReq=3'b111 held with reacks removed one at a time, rrPtr=0 at start -> grants in order 0,1,2; collisionCnt increments in each cycle with two or more requests (2 total).
REQ-022 Wrap-around: rrPtr=2 with wbReq=3'b011 -> grant 0, then grant 1.
REQ-023 Hold: wbReq=3'b001 with hold=1 for 3 cycles -> wbAck=0 and regWrEn=0 throughout; grant in the first cycle after hold=0.
REQ-024 Forwarding (macro on): grant write of 8'hFA to register 3, rSel1=3, rSel2=1 in cycle N+1 -> fwd1Valid=1, fwd1Data=8'hFA, fwd2Valid=0; macro off -> all fwd outputs 0.
REQ-025 Reset mid-operation: assert reset=0 between clock edges while regWrEn=1 -> all outputs reach REQ-015 values immediately; the target register is not written.
